chime_scheduler: RTL and testbench
==================================

# chime_scheduler

Sequences and arbitrates the single tone generator of the digital clock between three requesters: the alarm melody, the hourly chime and the key-press beep. It watches the running time, accepts alarm/key pulses, and drives one registered 20-bit tone half-period word (0 = silence) into the existing `ring` tone generator. It replaces ad-hoc per-second tone selection with a beat-timed state machine.

## Interface
- `BEAT_CYCLES`, 50_000_000, clk cycles per beat (0.5 s at 100 MHz); benches override with a small value.
- `BEEP_PERIOD`, 20'd113636, half-period for key beep and chime beeps.
- `ALARM_BEATS`, 64, alarm auto-timeout in beats.
- `clk  in  1  system clock`
- `rst_n  in  1  asynchronous, active-low reset`
- `on  in  1  speaker enable; 0 forces tone_period to 0, sequencing continues`
- `hour  in  6  current hour, 0..23`
- `min  in  6  current minute, 0..59`
- `sec  in  6  current second, 0..59`
- `alarm_hit  in  1  one-cycle pulse: alarm time reached`
- `alarm_stop  in  1  one-cycle pulse: user silences alarm`
- `key_beep  in  1  one-cycle pulse: key pressed`
- `tone_period  out  20  half-period word to ring; 0 = silent`
- `busy  out  1  1 whenever state != IDLE`
- `active_src  out  2  00 none, 01 key, 10 chime, 11 alarm`

## Operation
- States: IDLE, KEY, CHIME_ON, CHIME_OFF, ALARM.
- Beat counter: 0..BEAT_CYCLES-1, cleared on every state entry; "beat end" = counter at BEAT_CYCLES-1.
- Chime trigger: internal `sec_q` register (reset 0); trigger when min==0 && sec==0 && sec_q!=0. Beep count N = hour mod 12, with 0 mapped to 12; held in 4-bit `remaining`.
- Chime sequence: CHIME_ON (BEEP_PERIOD, 1 beat) -> CHIME_OFF (0, 1 beat); `remaining` decrements on leaving CHIME_ON; CHIME_OFF returns to CHIME_ON if remaining != 0, else IDLE.
- Alarm: 8-entry melody ROM, one entry per beat, index wraps 7->0: 113636, 170300, 151700, 191131, 0, 191131, 143184, 113636. Leaves to IDLE on alarm_stop or after ALARM_BEATS beat ends.
- Key: KEY state outputs BEEP_PERIOD for 1 beat, then IDLE.
- Priority alarm > chime > key. Simultaneous requests in IDLE: highest wins, others dropped except chime (see pending).
- alarm_hit in KEY/CHIME_*: abort immediately, enter ALARM, melody index 0. Aborted chime is not resumed.
- Chime trigger during ALARM: set `chime_pending`; on alarm exit go to CHIME_ON with N from hour at exit time, clear pending. Second trigger while pending: no effect.
- key_beep while busy: ignored. alarm_hit while in ALARM: restart melody index 0 and timeout count.
- alarm_stop outside ALARM: ignored.
- tone_period = 0 whenever on==0, in IDLE, and in CHIME_OFF.

## Timing
- Reset (async, rst_n low): state IDLE, tone_period 0, busy 0, active_src 00, remaining 0, chime_pending 0, sec_q 0, beat counter 0, melody index 0. Release takes effect on next clk edge.
- All outputs registered, updated on the same edge as the state transition: request pulse sampled at edge k -> new tone_period/busy/active_src visible after edge k.
- Beat length exactly BEAT_CYCLES cycles per state visit; N-beep chime occupies 2*N*BEAT_CYCLES cycles from trigger edge to IDLE.
- alarm_stop: tone_period 0, busy 0 after the sampling edge (or CHIME_ON if pending).
- `on` is sampled combinationally into the output register: toggling on changes tone_period one edge later without disturbing counters.
- Reset asserted mid-sequence: immediate return to reset values; no pending state survives.

## Test plan
- BEAT_CYCLES=4; time 03:59:59 -> 04:00:00 -> tone_period 113636 for 4 cycles, 0 for 4 cycles, repeated 4 times, then busy 0 after 32 cycles.
- hour=0 (and 12), min 0, sec 59->0 -> exactly 12 beeps; hour=13 -> 1 beep.
- key_beep in IDLE -> tone_period 113636 one edge later, 4 cycles, active_src 01; key_beep during chime -> no change in pattern.
- alarm_hit mid-chime -> next edge tone_period 113636, active_src 11, melody steps 170300,151700,... every 4 cycles; alarm_stop -> tone_period 0, busy 0, chime not resumed.
- chime trigger during alarm, then alarm times out after 64 beats -> chime of N(hour at exit) beeps follows immediately; on=0 throughout -> tone_period stays 0 while busy/active_src follow identical timing.
- rst_n pulsed low during CHIME_ON -> all outputs 0 asynchronously; no beep after release until next trigger.

Source files
------------

// File: rtl/chime_scheduler.sv
// Purpose: beat-timed arbiter/sequencer for the clock's single tone generator (alarm > chime > key).
// Latency: a request pulse sampled at edge k shows on tone_period/busy/active_src right after edge k.
// Backpressure: none; requests that lose arbitration are dropped, except a chime during the alarm, which is held pending.
module chime_scheduler #(
   parameter int          BEAT_CYCLES = 50_000_000,
   parameter logic [19:0] BEEP_PERIOD = 20'd113636,
   parameter int          ALARM_BEATS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        on,
   input  logic [5:0]  hour,
   input  logic [5:0]  min,
   input  logic [5:0]  sec,
   input  logic        alarm_hit,
   input  logic        alarm_stop,
   input  logic        key_beep,
   output logic [19:0] tone_period,
   output logic        busy,
   output logic [1:0]  active_src
);

   localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam int AW = (ALARM_BEATS > 1) ? $clog2(ALARM_BEATS) : 1;
   localparam logic [CW-1:0] BEAT_LAST  = CW'(BEAT_CYCLES - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_BEATS - 1);

   typedef enum logic [2:0] {IDLE, KEY, CHIME_ON, CHIME_OFF, ALARM} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [3:0]    remaining_q, remaining_d;
   logic          chime_pending_q, chime_pending_d;
   logic [5:0]    sec_q;
   logic [2:0]    mel_idx_q, mel_idx_d;
   logic [AW-1:0] alarm_beat_q, alarm_beat_d;
   logic [19:0]   tone_q, tone_d;
   logic          busy_q, busy_d;
   logic [1:0]    src_q, src_d;

   logic          chime_trig;
   logic          beat_end;
   logic          restart;
   logic [5:0]    hour12;
   logic [3:0]    n_beeps;

   // Melody ROM, one entry per beat; a zero entry is a rest.
   function automatic logic [19:0] melody(input logic [2:0] idx);
      case (idx)
         3'd0:    melody = 20'd113636;
         3'd1:    melody = 20'd170300;
         3'd2:    melody = 20'd151700;
         3'd3:    melody = 20'd191131;
         3'd4:    melody = 20'd0;
         3'd5:    melody = 20'd191131;
         3'd6:    melody = 20'd143184;
         default: melody = 20'd113636;
      endcase
   endfunction

   // Chime trigger fires on the second rolling over to xx:00:00; beep count is the 12-hour dial value.
   always_comb begin
      chime_trig = (min == 6'd0) && (sec == 6'd0) && (sec_q != 6'd0);
      beat_end   = (beat_cnt_q == BEAT_LAST);
      hour12     = (hour >= 6'd12) ? (hour - 6'd12) : hour;
      n_beeps    = (hour12 == 6'd0) ? 4'd12 : hour12[3:0];
   end

   // Next-state, sequencing counters and registered output values.
   always_comb begin
      state_d         = state_q;
      remaining_d     = remaining_q;
      chime_pending_d = chime_pending_q;
      mel_idx_d       = mel_idx_q;
      alarm_beat_d    = alarm_beat_q;
      restart         = 1'b0;

      // Any alarm_hit outside ALARM aborts whatever is playing; an aborted chime is lost.
      if (state_q != ALARM && alarm_hit) begin
         state_d         = ALARM;
         mel_idx_d       = 3'd0;
         alarm_beat_d    = '0;
         remaining_d     = 4'd0;
         chime_pending_d = chime_pending_q | chime_trig;
      end else begin
         case (state_q)
            IDLE: begin
               if (chime_trig) begin
                  state_d     = CHIME_ON;
                  remaining_d = n_beeps;
               end else if (key_beep) begin
                  state_d = KEY;
               end
            end
            KEY: begin
               if (chime_trig) begin
                  state_d     = CHIME_ON;
                  remaining_d = n_beeps;
               end else if (beat_end) begin
                  state_d = IDLE;
               end
            end
            CHIME_ON: begin
               if (beat_end) begin
                  state_d     = CHIME_OFF;
                  remaining_d = remaining_q - 4'd1;
               end
            end
            CHIME_OFF: begin
               if (beat_end) state_d = (remaining_q != 4'd0) ? CHIME_ON : IDLE;
            end
            ALARM: begin
               if (chime_trig) chime_pending_d = 1'b1;
               if (alarm_hit) begin
                  restart      = 1'b1;
                  mel_idx_d    = 3'd0;
                  alarm_beat_d = '0;
               end else if (alarm_stop || (beat_end && alarm_beat_q == ALARM_LAST)) begin
                  // A chime held off by the alarm plays now, counted from the hour at exit.
                  if (chime_pending_d) begin
                     state_d         = CHIME_ON;
                     remaining_d     = n_beeps;
                     chime_pending_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (beat_end) begin
                  mel_idx_d    = mel_idx_q + 3'd1;
                  alarm_beat_d = alarm_beat_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Every state visit starts a fresh beat.
      if (state_d != state_q || restart || beat_end || state_d == IDLE) beat_cnt_d = '0;
      else                                                               beat_cnt_d = beat_cnt_q + 1'b1;

      tone_d = 20'd0;
      src_d  = 2'b00;
      case (state_d)
         KEY:       begin tone_d = BEEP_PERIOD;         src_d = 2'b01; end
         CHIME_ON:  begin tone_d = BEEP_PERIOD;         src_d = 2'b10; end
         CHIME_OFF: begin                               src_d = 2'b10; end
         ALARM:     begin tone_d = melody(mel_idx_d);   src_d = 2'b11; end
         default:   begin                                              end
      endcase
      if (!on) tone_d = 20'd0;
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         beat_cnt_q      <= '0;
         remaining_q     <= 4'd0;
         chime_pending_q <= 1'b0;
         sec_q           <= 6'd0;
         mel_idx_q       <= 3'd0;
         alarm_beat_q    <= '0;
         tone_q          <= 20'd0;
         busy_q          <= 1'b0;
         src_q           <= 2'b00;
      end else begin
         state_q         <= state_d;
         beat_cnt_q      <= beat_cnt_d;
         remaining_q     <= remaining_d;
         chime_pending_q <= chime_pending_d;
         sec_q           <= sec;
         mel_idx_q       <= mel_idx_d;
         alarm_beat_q    <= alarm_beat_d;
         tone_q          <= tone_d;
         busy_q          <= busy_d;
         src_q           <= src_d;
      end
   end

   assign tone_period = tone_q;
   assign busy        = busy_q;
   assign active_src  = src_q;

endmodule

// File: tb/tb_chime_scheduler.sv
// Purpose: directed bench for chime_scheduler with a 4-cycle beat.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_chime_scheduler;

   localparam int          BEAT = 4;
   localparam logic [19:0] BEEP = 20'd113636;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        on;
   logic [5:0]  hour, min, sec;
   logic        alarm_hit, alarm_stop, key_beep;
   logic [19:0] tone_period;
   logic        busy;
   logic [1:0]  active_src;

   int checks = 0;
   int errors = 0;

   logic [19:0] mel_tab [8] = '{20'd113636, 20'd170300, 20'd151700, 20'd191131,
                                20'd0,      20'd191131, 20'd143184, 20'd113636};

   chime_scheduler #(.BEAT_CYCLES(BEAT), .BEEP_PERIOD(BEEP), .ALARM_BEATS(64)) dut (
      .clk(clk), .rst_n(rst_n), .on(on), .hour(hour), .min(min), .sec(sec),
      .alarm_hit(alarm_hit), .alarm_stop(alarm_stop), .key_beep(key_beep),
      .tone_period(tone_period), .busy(busy), .active_src(active_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tone"}, tone_period, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_src"},  active_src, 0);
   endtask

   // Called just after the trigger edge; walks the whole N-beep pattern.
   task automatic check_chime(input int n, input int key_at);
      for (int i = 0; i < 8 * n; i++) begin
         check("chime_tone", tone_period, (on && (i % 8) < 4) ? BEEP : 20'd0);
         check("chime_busy", busy, 1);
         check("chime_src",  active_src, 2);
         if (i == key_at) key_beep = 1'b1;
         tick(1);
         key_beep = 1'b0;
      end
      check_idle("chime_end");
   endtask

   // Second rolls 59 -> 0 at minute 0 of hour h; returns just after the trigger edge.
   task automatic trigger_chime(input logic [5:0] h);
      hour = h; min = 6'd0; sec = 6'd59;
      tick(1);
      sec = 6'd0;
      tick(1);
   endtask

   initial begin
      rst_n = 1'b0; on = 1'b1;
      hour = 6'd3; min = 6'd59; sec = 6'd59;
      alarm_hit = 1'b0; alarm_stop = 1'b0; key_beep = 1'b0;
      #12;
      check_idle("reset");
      tick(1);
      rst_n = 1'b1;
      tick(2);
      check_idle("post_reset");

      // 03:59:59 -> 04:00:00: four beeps.
      hour = 6'd4; min = 6'd0; sec = 6'd0;
      tick(1);
      check_chime(4, -1);
      tick(3);
      check_idle("no_retrigger");

      // Hour 0 maps to 12 beeps, hour 13 to one.
      trigger_chime(6'd0);
      check_chime(12, -1);
      trigger_chime(6'd13);
      check_chime(1, -1);

      // Key beep in IDLE.
      key_beep = 1'b1;
      tick(1);
      key_beep = 1'b0;
      for (int i = 0; i < BEAT; i++) begin
         check("key_tone", tone_period, BEEP);
         check("key_busy", busy, 1);
         check("key_src",  active_src, 1);
         tick(1);
      end
      check_idle("key_end");

      // Key beep during a chime does not disturb it.
      trigger_chime(6'd2);
      check_chime(2, 2);

      // Alarm aborts a chime mid-sequence; melody walks and wraps; stop ends it.
      trigger_chime(6'd5);
      tick(5);
      alarm_hit = 1'b1;
      tick(1);
      alarm_hit = 1'b0;
      for (int i = 0; i < 9 * BEAT; i++) begin
         check("alarm_tone", tone_period, mel_tab[(i / BEAT) % 8]);
         check("alarm_src",  active_src, 3);
         tick(1);
      end
      alarm_stop = 1'b1;
      tick(1);
      alarm_stop = 1'b0;
      check_idle("alarm_stop");
      tick(20);
      check_idle("chime_not_resumed");

      // Speaker off: chime pending during alarm, alarm times out, chime of 9 follows.
      on = 1'b0;
      hour = 6'd7; min = 6'd59; sec = 6'd59;
      tick(1);
      alarm_hit = 1'b1;
      tick(1);
      alarm_hit = 1'b0;
      for (int i = 0; i < 64 * BEAT; i++) begin
         check("to_tone", tone_period, 0);
         check("to_busy", busy, 1);
         check("to_src",  active_src, 3);
         if (i == 10) begin hour = 6'd8; min = 6'd0; sec = 6'd0; end
         if (i == 30) begin sec = 6'd59; end
         if (i == 31) begin sec = 6'd0; end
         if (i == 40) hour = 6'd9;
         tick(1);
      end
      check_chime(9, -1);
      on = 1'b1;

      // Reset in CHIME_ON clears everything at once; nothing plays after release.
      trigger_chime(6'd6);
      tick(2);
      check("rst_pre_tone", tone_period, BEEP);
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check("post_rst_busy", busy, 0);
         tick(1);
      end
      check_idle("post_rst_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case something wedges.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
